// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_RESP   = 3'd3,
    S_READ2  = 3'd4,
    S_WRITE2 = 3'd5
  } state_e;

  localparam logic [2:0] WRITE_STATE = 3'b011;
  localparam logic [2:0] IDLE_STATE  = 3'b000;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane merge (store) and extract/extend (load) over a WB-byte window.
// The window is 8 bytes normally, 16 when misaligned accesses are split.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int WB = 8
) (
  input  logic [2:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  input  logic [8*WB-1:0] old_i,
  input  logic [63:0]     new_i,
  output logic [8*WB-1:0] merged_o,
  output logic [63:0]     load_o
);

  logic [63:0]     fmask, raw;
  logic [8*WB-1:0] mask, shifted;

  // Replace bytes [off .. off+n-1] of old with new; pull the field at off back out.
  always_comb begin
    fmask    = (size_e'(size_i) == SZ_D) ? '1
             : ((64'd1 << {nbytes(size_i), 3'b000}) - 64'd1);
    mask     = (8*WB)'(fmask) << {off_i, 3'b000};
    merged_o = (old_i & ~mask) | (((8*WB)'(new_i) << {off_i, 3'b000}) & mask);
    shifted  = old_i >> {off_i, 3'b000};
    raw      = shifted[63:0];
    case (size_e'(size_i))
      SZ_B:    load_o = {{56{signed_i & raw[7]}},  raw[7:0]};
      SZ_H:    load_o = {{48{signed_i & raw[15]}}, raw[15:0]};
      SZ_W:    load_o = {{32{signed_i & raw[31]}}, raw[31:0]};
      default: load_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of the RAM rw port. Sub-doubleword stores are
// done as aligned read-modify-write because the RAM only writes 8 bytes.
// Optional: LSU_MISALIGN_SPLIT_EN runs doubleword-crossing accesses as two
// aligned accesses (low, then aligned+8) instead of flagging an error.
module lsu #(
  parameter int         MEM_SIZE    = 524288,
  parameter logic [2:0] WRITE_STATE = lsu_pkg::WRITE_STATE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [2:0]  mem_state,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write_en,
  input  logic [63:0] mem_rdata,
  input  logic        mem_error
);
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int WB    = 16;
  localparam bit SPLIT = 1'b1;
`else
  localparam int WB    = 8;
  localparam bit SPLIT = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [63:0]     addr_q, wdata_q, mdata_q, rdata_q, acc_addr, lane_load;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            sgn_q, write_q, err_q, mis, rd_err, split_mis;
  logic [8*WB-1:0] lane_old, lane_merged;

  assign mis = ({1'b0, req_addr[2:0]} + nbytes(req_size)) > 4'd8;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [63:0] lo_q;
  logic        mis_q;
  assign split_mis = mis_q;
  // Second-half read sees the saved low doubleword underneath it.
  assign lane_old  = {mem_rdata, (state_q == S_READ2) ? lo_q : mem_rdata};
  assign acc_addr  = (state_q == S_READ2 || state_q == S_WRITE2) ? addr_q + 64'd8 : addr_q;
`else
  assign split_mis = 1'b0;
  assign lane_old  = mem_rdata;
  assign acc_addr  = addr_q;
`endif

  // Out-of-range is already flagged by the RAM; the local check is a backstop.
  assign rd_err = mem_error | (acc_addr >= 64'(MEM_SIZE));

  lsu_lane #(.WB(WB)) u_lane (
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .old_i    (lane_old),
    .new_i    (wdata_q),
    .merged_o (lane_merged),
    .load_o   (lane_load)
  );

  // Next state and all port outputs decode from the current state.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_error   = 1'b0;
    mem_state    = IDLE_STATE;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    mem_addr     = (state_q == S_IDLE) ? '0 : acc_addr;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (mis && !SPLIT)                                     state_d = S_RESP;
          else if (req_write && !mis && size_e'(req_size) == SZ_D) state_d = S_WRITE;
          else                                                   state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_err)         state_d = S_RESP;
        else if (write_q)   state_d = S_WRITE;
        else if (split_mis) state_d = S_READ2;
        else                state_d = S_RESP;
      end
      S_WRITE: begin
        mem_state    = WRITE_STATE;
        mem_write_en = 1'b1;
        mem_wdata    = mdata_q;
        state_d      = (split_mis && !rd_err) ? S_READ2 : S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_READ2: state_d = (write_q && !rd_err) ? S_WRITE2 : S_RESP;
      S_WRITE2: begin
        mem_state    = WRITE_STATE;
        mem_write_en = 1'b1;
        mem_wdata    = mdata_q;
        state_d      = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus request latch and per-access capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q    <= '0;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= {req_addr[63:3], 3'b000};
          off_q   <= req_addr[2:0];
          size_q  <= req_size;
          sgn_q   <= req_signed;
          write_q <= req_write;
          wdata_q <= req_wdata;
          mdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= mis && !SPLIT;
`ifdef LSU_MISALIGN_SPLIT_EN
          mis_q   <= mis;
`endif
        end
        S_READ: begin
          err_q   <= rd_err;
          mdata_q <= lane_merged[63:0];
          if (!write_q && !rd_err && !split_mis) rdata_q <= lane_load;
`ifdef LSU_MISALIGN_SPLIT_EN
          lo_q    <= mem_rdata;
`endif
        end
        S_WRITE: err_q <= rd_err;
`ifdef LSU_MISALIGN_SPLIT_EN
        S_READ2: begin
          err_q   <= rd_err;
          mdata_q <= lane_merged[127:64];
          if (!write_q && !rd_err) rdata_q <= lane_load;
        end
        S_WRITE2: err_q <= rd_err;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural RAM (combinational read,
// write on clock edge when enabled, in write state and in range).
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [63:0] resp_rdata;
  logic [2:0]  mem_state;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write_en, mem_error;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int bad_st   = 0;

  logic [63:0] ram [0:65535] = '{default: 64'd0};

  always #5 clk = ~clk;

  lsu #(.MEM_SIZE(524288), .WRITE_STATE(3'b011)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_state(mem_state), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  assign mem_error = (mem_addr >= 64'd524288);
  assign mem_rdata = mem_error ? 64'd0 : ram[mem_addr[18:3]];

  always @(posedge clk)
    if (mem_write_en && mem_state == 3'b011 && !mem_error)
      ram[mem_addr[18:3]] <= mem_wdata;

  always @(negedge clk)
    if (mem_write_en === 1'b1) begin
      wr_cnt++;
      if (mem_state !== 3'b011) bad_st++;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: drive in IDLE, count negedges to resp_valid, check results.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] e_rd, input logic e_er,
                      input int e_lat, input int e_pulses);
    int w0, b0, lat;
    @(negedge clk);
    w0 = wr_cnt; b0 = bad_st;
    chk({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp_valid !== 1'b1 && lat < 20);
    chk({tag, ".resp_seen"}, 64'(resp_valid), 64'd1);
    chk({tag, ".latency"},   64'(lat), 64'(e_lat));
    chk({tag, ".rdata"},     resp_rdata, e_rd);
    chk({tag, ".error"},     64'(resp_error), 64'(e_er));
    chk({tag, ".ready_resp"}, 64'(req_ready), 64'd0);
    chk({tag, ".we_pulses"}, 64'(wr_cnt - w0), 64'(e_pulses));
    chk({tag, ".we_state"},  64'(bad_st - b0), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    #12;
    chk("rst.ready",  64'(req_ready), 64'd1);
    chk("rst.rvalid", 64'(resp_valid), 64'd0);
    chk("rst.rdata",  resp_rdata, 64'd0);
    chk("rst.rerr",   64'(resp_error), 64'd0);
    chk("rst.we",     64'(mem_write_en), 64'd0);
    chk("rst.state",  64'(mem_state), 64'd0);
    chk("rst.addr",   mem_addr, 64'd0);
    chk("rst.wdata",  mem_wdata, 64'd0);
    @(negedge clk) reset = 1'b1;

    // 8B aligned store, then signed byte load of the top byte
    xact("st8",  1'b1, 2'd3, 1'b0, 64'h100, 64'h1122334455667788, 64'd0, 1'b0, 2, 1);
    chk("st8.ram", ram[32], 64'h1122334455667788);
    xact("ld1s", 1'b0, 2'd0, 1'b1, 64'h107, 64'd0, 64'h11, 1'b0, 2, 0);

    // byte store via read-modify-write
    xact("st1",  1'b1, 2'd0, 1'b0, 64'h103, 64'hAB, 64'd0, 1'b0, 3, 1);
    xact("ld8",  1'b0, 2'd3, 1'b1, 64'h100, 64'd0, 64'h11223344AB667788, 1'b0, 2, 0);

    // half store, signed and unsigned reload
    xact("st2",  1'b1, 2'd1, 1'b0, 64'h106, 64'hFFEE, 64'd0, 1'b0, 3, 1);
    xact("ld2s", 1'b0, 2'd1, 1'b1, 64'h106, 64'd0, 64'hFFFFFFFFFFFFFFEE, 1'b0, 2, 0);
    xact("ld2u", 1'b0, 2'd1, 1'b0, 64'h106, 64'd0, 64'h000000000000FFEE, 1'b0, 2, 0);

    // top of memory: last word in range, first word out of range
    xact("st4top", 1'b1, 2'd2, 1'b0, 64'd524284, 64'hDEADBEEF, 64'd0, 1'b0, 3, 1);
    xact("ld4u",   1'b0, 2'd2, 1'b0, 64'd524284, 64'd0, 64'h00000000DEADBEEF, 1'b0, 2, 0);
    xact("ld4s",   1'b0, 2'd2, 1'b1, 64'd524284, 64'd0, 64'hFFFFFFFFDEADBEEF, 1'b0, 2, 0);
    xact("st8oob", 1'b1, 2'd3, 1'b0, 64'd524288, 64'h5555555555555555, 64'd0, 1'b1, 2, 1);
    chk("oob.ram_top", ram[65535], 64'hDEADBEEF00000000);
    chk("oob.ram_0",   ram[0], 64'd0);

    // misaligned accesses crossing 0x108
    xact("st8b", 1'b1, 2'd3, 1'b0, 64'h108, 64'h0706050403020199, 64'd0, 1'b0, 2, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    xact("ld4mis", 1'b0, 2'd2, 1'b0, 64'h105, 64'd0, 64'h0000000099FFEE33, 1'b0, 3, 0);
    xact("st2mis", 1'b1, 2'd1, 1'b0, 64'h107, 64'hCAFE, 64'd0, 1'b0, 5, 2);
    chk("st2mis.lo", ram[32], 64'hFEEE3344AB667788);
    chk("st2mis.hi", ram[33], 64'h07060504030201CA);
`else
    xact("ld4mis", 1'b0, 2'd2, 1'b0, 64'h105, 64'd0, 64'd0, 1'b1, 1, 0);
    xact("st2mis", 1'b1, 2'd1, 1'b0, 64'h107, 64'hCAFE, 64'd0, 1'b1, 1, 0);
    chk("st2mis.lo", ram[32], 64'hFFEE3344AB667788);
    chk("st2mis.hi", ram[33], 64'h0706050403020199);
`endif

    // reset asserted while a 2B store sits in WRITE
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 64'h200; req_wdata = 64'h1234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.we_before", 64'(mem_write_en), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort.we_after", 64'(mem_write_en), 64'd0);
    chk("abort.state",    64'(mem_state), 64'd0);
    chk("abort.rvalid",   64'(resp_valid), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("abort.ready",    64'(req_ready), 64'd1);
    chk("abort.rvalid2",  64'(resp_valid), 64'd0);
    chk("abort.ram",      ram[64], 64'd0);
    xact("post_abort", 1'b0, 2'd3, 1'b0, 64'h100, 64'd0,
`ifdef LSU_MISALIGN_SPLIT_EN
         64'hFEEE3344AB667788,
`else
         64'hFFEE3344AB667788,
`endif
         1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
